rocc_cmd_arbiter: RTL and testbench

Shares one RoCC accelerator command/response channel among `NREQ` requesters. Commands are granted round-robin into a one-entry output register that drives the accelerator. The source ID of every command expecting a response (`xd=1`) is recorded in an in-order tag FIFO. Accelerator responses are steered back to the recorded requester, so several request streams can drive a single accumulator-style accelerator without knowing about each other.

---
 rtl/rocc_cmd_arbiter.sv | 145 ++++++++++++++
 tb/tb_rocc_cmd_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_cmd_arbiter.sv
// Round-robin arbiter sharing one RoCC command/response channel among NREQ requesters.
// Commands go through a one-entry holding register; response owners are tracked in an in-order tag FIFO.
module rocc_cmd_arbiter #(
   parameter int xLen  = 64,
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_cmd_valid,
   output logic [NREQ-1:0]      req_cmd_ready,
   input  logic [7*NREQ-1:0]    req_cmd_funct,
   input  logic [5*NREQ-1:0]    req_cmd_rd,
   input  logic [NREQ-1:0]      req_cmd_xd,
   input  logic [xLen*NREQ-1:0] req_cmd_rs1,
   input  logic [xLen*NREQ-1:0] req_cmd_rs2,
   output logic                 acc_cmd_valid,
   input  logic                 acc_cmd_ready,
   output logic [6:0]           acc_cmd_funct,
   output logic [4:0]           acc_cmd_rd,
   output logic                 acc_cmd_xd,
   output logic [xLen-1:0]      acc_cmd_rs1,
   output logic [xLen-1:0]      acc_cmd_rs2,
   input  logic                 acc_resp_valid,
   output logic                 acc_resp_ready,
   input  logic [4:0]           acc_resp_rd,
   input  logic [xLen-1:0]      acc_resp_data,
   output logic [NREQ-1:0]      req_resp_valid,
   input  logic [NREQ-1:0]      req_resp_ready,
   output logic [4:0]           req_resp_rd,
   output logic [xLen-1:0]      req_resp_data,
   output logic                 busy,
   output logic                 resp_orphan
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            hr_valid;
   logic [6:0]      hr_funct;
   logic [4:0]      hr_rd;
   logic            hr_xd;
   logic [xLen-1:0] hr_rs1;
   logic [xLen-1:0] hr_rs2;

   logic [IDW-1:0]  rr;
   logic [IDW-1:0]  winner;
   logic            found;
   logic            load_en;
   logic            load;
   logic            fifo_block;
   logic            push;
   logic            pop;
   logic            fifo_empty;

   logic [CW-1:0]   count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [IDW-1:0]  tags [DEPTH];
   logic [IDW-1:0]  head;

   // Round-robin search starting at rr, wrapping past NREQ-1 back to 0.
   always_comb begin : arb_search
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr) + k) % NREQ;
         if (!found && req_cmd_valid[idx]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   // A full tag FIFO stalls every requester, even xd=0 ones, to keep ordering simple.
   assign fifo_block    = (count == CW'(DEPTH));
   assign load_en       = (!hr_valid || acc_cmd_ready) && !fifo_block;
   assign load          = load_en && found;
   assign req_cmd_ready = load ? (NREQ'(1) << winner) : '0;
   assign push          = load && req_cmd_xd[winner];

   assign acc_cmd_valid = hr_valid;
   assign acc_cmd_funct = hr_funct;
   assign acc_cmd_rd    = hr_rd;
   assign acc_cmd_xd    = hr_xd;
   assign acc_cmd_rs1   = hr_rs1;
   assign acc_cmd_rs2   = hr_rs2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hr_valid <= 1'b0;
         hr_funct <= '0;
         hr_rd    <= '0;
         hr_xd    <= 1'b0;
         hr_rs1   <= '0;
         hr_rs2   <= '0;
         rr       <= '0;
      end else if (load) begin
         hr_valid <= 1'b1;
         hr_funct <= req_cmd_funct[winner*7 +: 7];
         hr_rd    <= req_cmd_rd[winner*5 +: 5];
         hr_xd    <= req_cmd_xd[winner];
         hr_rs1   <= req_cmd_rs1[winner*xLen +: xLen];
         hr_rs2   <= req_cmd_rs2[winner*xLen +: xLen];
         rr       <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end else if (acc_cmd_ready) begin
         hr_valid <= 1'b0;
      end
   end

   // Responses go to the oldest recorded owner; with no owner they are swallowed.
   assign fifo_empty     = (count == '0);
   assign head           = tags[rd_ptr];
   assign req_resp_valid = fifo_empty ? '0 : (NREQ'(acc_resp_valid) << head);
   assign acc_resp_ready = fifo_empty ? 1'b1 : req_resp_ready[head];
   assign pop            = !fifo_empty && acc_resp_valid && req_resp_ready[head];
   assign req_resp_rd    = acc_resp_rd;
   assign req_resp_data  = acc_resp_data;

   assign busy = hr_valid || !fifo_empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         resp_orphan <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (acc_resp_valid && fifo_empty) resp_orphan <= 1'b1;
      end
   end

   // Tag storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clock) begin
      if (push) tags[wr_ptr] <= winner;
   end

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed, table-driven bench for rocc_cmd_arbiter (NREQ=4, DEPTH=4).
// Requester i normally drives funct=0x10+i, rd=i+1, rs1=0x100+i, rs2=0x200+i.
module tb_rocc_cmd_arbiter;

   localparam int XLEN  = 64;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int DEPTH = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [NREQ-1:0]      req_cmd_valid = '0;
   logic [NREQ-1:0]      req_cmd_ready;
   logic [7*NREQ-1:0]    req_cmd_funct = '0;
   logic [5*NREQ-1:0]    req_cmd_rd = '0;
   logic [NREQ-1:0]      req_cmd_xd = '0;
   logic [XLEN*NREQ-1:0] req_cmd_rs1 = '0;
   logic [XLEN*NREQ-1:0] req_cmd_rs2 = '0;
   logic                 acc_cmd_valid;
   logic                 acc_cmd_ready = 1'b0;
   logic [6:0]           acc_cmd_funct;
   logic [4:0]           acc_cmd_rd;
   logic                 acc_cmd_xd;
   logic [XLEN-1:0]      acc_cmd_rs1;
   logic [XLEN-1:0]      acc_cmd_rs2;
   logic                 acc_resp_valid = 1'b0;
   logic                 acc_resp_ready;
   logic [4:0]           acc_resp_rd = '0;
   logic [XLEN-1:0]      acc_resp_data = '0;
   logic [NREQ-1:0]      req_resp_valid;
   logic [NREQ-1:0]      req_resp_ready = '0;
   logic [4:0]           req_resp_rd;
   logic [XLEN-1:0]      req_resp_data;
   logic                 busy;
   logic                 resp_orphan;

   int checks = 0;
   int errors = 0;

   rocc_cmd_arbiter #(.xLen(XLEN), .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
      .req_cmd_funct(req_cmd_funct), .req_cmd_rd(req_cmd_rd), .req_cmd_xd(req_cmd_xd),
      .req_cmd_rs1(req_cmd_rs1), .req_cmd_rs2(req_cmd_rs2),
      .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
      .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
      .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
      .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
      .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data),
      .req_resp_valid(req_resp_valid), .req_resp_ready(req_resp_ready),
      .req_resp_rd(req_resp_rd), .req_resp_data(req_resp_data),
      .busy(busy), .resp_orphan(resp_orphan)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] xd;
      logic       acc_ready;
      logic [3:0] exp_ready;
      logic       exp_hv;
      logic [6:0] exp_funct;
      logic       exp_busy;
      logic [2:0] exp_count;
   } vec_t;

   vec_t vecs [18];

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic set_default_fields();
      for (int i = 0; i < NREQ; i++) begin
         req_cmd_funct[i*7 +: 7]       = 7'(16 + i);
         req_cmd_rd[i*5 +: 5]          = 5'(i + 1);
         req_cmd_rs1[i*XLEN +: XLEN]   = 64'(256 + i);
         req_cmd_rs2[i*XLEN +: XLEN]   = 64'(512 + i);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] valid, input logic [3:0] xd, input logic ar,
                                 input logic rv, input logic [3:0] rrdy, input logic [4:0] rrd,
                                 input logic [63:0] rdata);
      @(negedge clock);
      req_cmd_valid  = valid;
      req_cmd_xd     = xd;
      acc_cmd_ready  = ar;
      acc_resp_valid = rv;
      req_resp_ready = rrdy;
      acc_resp_rd    = rrd;
      acc_resp_data  = rdata;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [1:0] heads [4];

   initial begin
      // Round robin with xd=0, then backpressure, then FIFO fill to the stall point.
      vecs[0]  = '{4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 7'h10, 1'b1, 3'd0};
      vecs[1]  = '{4'hF, 4'h0, 1'b1, 4'b0010, 1'b1, 7'h11, 1'b1, 3'd0};
      vecs[2]  = '{4'hF, 4'h0, 1'b1, 4'b0100, 1'b1, 7'h12, 1'b1, 3'd0};
      vecs[3]  = '{4'hF, 4'h0, 1'b1, 4'b1000, 1'b1, 7'h13, 1'b1, 3'd0};
      vecs[4]  = '{4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 7'h10, 1'b1, 3'd0};
      vecs[5]  = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 7'h10, 1'b0, 3'd0};
      vecs[6]  = '{4'h5, 4'h0, 1'b0, 4'b0100, 1'b1, 7'h12, 1'b1, 3'd0};
      vecs[7]  = '{4'h5, 4'h0, 1'b0, 4'b0000, 1'b1, 7'h12, 1'b1, 3'd0};
      vecs[8]  = '{4'h5, 4'h0, 1'b0, 4'b0000, 1'b1, 7'h12, 1'b1, 3'd0};
      vecs[9]  = '{4'h5, 4'h0, 1'b0, 4'b0000, 1'b1, 7'h12, 1'b1, 3'd0};
      vecs[10] = '{4'h5, 4'h0, 1'b1, 4'b0001, 1'b1, 7'h10, 1'b1, 3'd0};
      vecs[11] = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 7'h10, 1'b0, 3'd0};
      vecs[12] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 7'h11, 1'b1, 3'd1};
      vecs[13] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 7'h12, 1'b1, 3'd2};
      vecs[14] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 7'h13, 1'b1, 3'd3};
      vecs[15] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 7'h10, 1'b1, 3'd4};
      vecs[16] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 7'h10, 1'b1, 3'd4};
      vecs[17] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 7'h10, 1'b1, 3'd4};

      set_default_fields();
      #12;
      check_output("rst acc_cmd_valid", 64'(acc_cmd_valid), 64'd0);
      check_output("rst busy", 64'(busy), 64'd0);
      check_output("rst req_resp_valid", 64'(req_resp_valid), 64'd0);
      check_output("rst req_cmd_ready", 64'(req_cmd_ready), 64'd0);
      check_output("rst resp_orphan", 64'(resp_orphan), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_output("post-rst acc_resp_ready", 64'(acc_resp_ready), 64'd1);

      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i].valid, vecs[i].xd, vecs[i].acc_ready, 1'b0, 4'hF, 5'd0, 64'd0);
         check_output($sformatf("v%0d req_cmd_ready", i), 64'(req_cmd_ready), 64'(vecs[i].exp_ready));
         tick();
         check_output($sformatf("v%0d acc_cmd_valid", i), 64'(acc_cmd_valid), 64'(vecs[i].exp_hv));
         check_output($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
         check_output($sformatf("v%0d count", i), 64'(dut.count), 64'(vecs[i].exp_count));
         if (vecs[i].exp_hv) begin
            check_output($sformatf("v%0d funct", i), 64'(acc_cmd_funct), 64'(vecs[i].exp_funct));
            check_output($sformatf("v%0d rs1", i), acc_cmd_rs1, 64'(256 + int'(vecs[i].exp_funct) - 16));
            check_output($sformatf("v%0d rd", i), 64'(acc_cmd_rd), 64'(int'(vecs[i].exp_funct) - 15));
            check_output($sformatf("v%0d xd", i), 64'(acc_cmd_xd), 64'(vecs[i].xd[0]));
         end
      end

      // Full FIFO: a same-cycle pop must not lift the stall; the grant follows next cycle.
      apply_stimulus(4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 5'd2, 64'hAAAA);
      check_output("full pop cmd_ready", 64'(req_cmd_ready), 64'd0);
      check_output("full pop resp_valid", 64'(req_resp_valid), 64'b0010);
      check_output("full pop acc_resp_ready", 64'(acc_resp_ready), 64'd1);
      check_output("full pop resp_data", req_resp_data, 64'hAAAA);
      check_output("full pop resp_rd", 64'(req_resp_rd), 64'd2);
      tick();
      check_output("after pop count", 64'(dut.count), 64'd3);
      apply_stimulus(4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 5'd0, 64'd0);
      check_output("stalled grant ready", 64'(req_cmd_ready), 64'b0010);
      tick();
      check_output("stalled grant funct", 64'(acc_cmd_funct), 64'h11);
      check_output("stalled grant count", 64'(dut.count), 64'd4);

      // Head owner (2) not ready: response held, FIFO untouched.
      apply_stimulus(4'h0, 4'h0, 1'b1, 1'b1, 4'b1011, 5'd9, 64'h55);
      check_output("held acc_resp_ready", 64'(acc_resp_ready), 64'd0);
      check_output("held resp_valid", 64'(req_resp_valid), 64'b0100);
      tick();
      check_output("held count", 64'(dut.count), 64'd4);

      heads[0] = 2'd2; heads[1] = 2'd3; heads[2] = 2'd0; heads[3] = 2'd1;
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 5'(k), 64'(1000 + k));
         check_output($sformatf("drain%0d resp_valid", k), 64'(req_resp_valid), 64'(4'b0001 << heads[k]));
         check_output($sformatf("drain%0d resp_data", k), req_resp_data, 64'(1000 + k));
         tick();
         check_output($sformatf("drain%0d count", k), 64'(dut.count), 64'(3 - k));
      end
      check_output("drained busy", 64'(busy), 64'd0);

      // Requester 2 sends rs1=5 rs2=7 rd=3 xd=1; accelerator answers 12.
      req_cmd_funct[2*7 +: 7]        = 7'h22;
      req_cmd_rd[2*5 +: 5]           = 5'd3;
      req_cmd_rs1[2*XLEN +: XLEN]    = 64'd5;
      req_cmd_rs2[2*XLEN +: XLEN]    = 64'd7;
      apply_stimulus(4'b0100, 4'b0100, 1'b1, 1'b0, 4'hF, 5'd0, 64'd0);
      check_output("r2 cmd_ready", 64'(req_cmd_ready), 64'b0100);
      tick();
      check_output("r2 rs1", acc_cmd_rs1, 64'd5);
      check_output("r2 rs2", acc_cmd_rs2, 64'd7);
      check_output("r2 rd", 64'(acc_cmd_rd), 64'd3);
      check_output("r2 xd", 64'(acc_cmd_xd), 64'd1);
      check_output("r2 count", 64'(dut.count), 64'd1);
      apply_stimulus(4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 5'd3, 64'd12);
      check_output("r2 resp_valid", 64'(req_resp_valid), 64'b0100);
      check_output("r2 resp_data", req_resp_data, 64'd12);
      check_output("r2 resp_rd", 64'(req_resp_rd), 64'd3);
      tick();
      check_output("r2 count after", 64'(dut.count), 64'd0);
      check_output("r2 busy after", 64'(busy), 64'd0);
      set_default_fields();

      // Orphan response with the FIFO empty.
      check_output("orphan before", 64'(resp_orphan), 64'd0);
      apply_stimulus(4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 5'd1, 64'd77);
      check_output("orphan acc_resp_ready", 64'(acc_resp_ready), 64'd1);
      check_output("orphan resp_valid", 64'(req_resp_valid), 64'd0);
      tick();
      check_output("orphan sticky", 64'(resp_orphan), 64'd1);

      // Two outstanding tags and a stalled HR, then an asynchronous mid-cycle reset.
      apply_stimulus(4'b0011, 4'b0011, 1'b1, 1'b0, 4'h0, 5'd0, 64'd0);
      tick();
      apply_stimulus(4'b0011, 4'b0011, 1'b1, 1'b0, 4'h0, 5'd0, 64'd0);
      tick();
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 5'd0, 64'd0);
      check_output("pre-rst count", 64'(dut.count), 64'd2);
      check_output("pre-rst hr", 64'(acc_cmd_valid), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check_output("async rst acc_cmd_valid", 64'(acc_cmd_valid), 64'd0);
      check_output("async rst busy", 64'(busy), 64'd0);
      check_output("async rst count", 64'(dut.count), 64'd0);
      check_output("async rst orphan", 64'(resp_orphan), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      apply_stimulus(4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 5'd0, 64'd0);
      check_output("rr after rst", 64'(req_cmd_ready), 64'b0001);
      tick();
      check_output("rr after rst funct", 64'(acc_cmd_funct), 64'h10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
